ex_muldiv: RTL and testbench
============================

# ex_muldiv

Multi-cycle multiply/divide unit in the EX stage. It consumes the operands and funct field produced by the ID/EX pipeline register and returns a 32-bit result for the EX/MEM register. It holds the front of the pipeline with `busy_o` while it iterates. It obeys the same `memstall_i` freeze as the other pipeline registers.

## Interface

Parameters:
- `WIDTH`, default 32: operand and result width.
- `ITER`, default `WIDTH`: number of iteration cycles.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `memstall_i` in 1: data-cache stall; freezes all state.
- `start_i` in 1: request from ID/EX, qualified by funct.
- `funct_i` in 6: `MULU` = 6'b011001, `DIVU` = 6'b011011; other codes are ignored.
- `rsdata_i` in `WIDTH`: multiplicand or dividend.
- `rtdata_i` in `WIDTH`: multiplier or divisor.
- `rdaddr_i` in 5: destination register.
- `busy_o` out 1: stall request to IF/ID, ID/EX and the PC.
- `done_o` out 1: result valid this cycle.
- `result_o` out `WIDTH`: low product, or quotient.
- `rem_o` out `WIDTH`: remainder; 0 for multiply.
- `rdaddr_o` out 5: destination captured at start.

## Operation

States are IDLE, MUL, DIV and DONE.
- **Accepting a request (IDLE):** a request is accepted on an edge where `start_i`=1, the funct is valid and `memstall_i`=0.
  - It captures the operands and `rdaddr_i`, clears the accumulator, and loads the counter with 0.
  - `MULU` goes to MUL.
  - `DIVU` with a nonzero divisor goes to DIV.
  - `DIVU` with a zero divisor goes directly to DONE with quotient `{WIDTH{1'b1}}` and remainder = dividend.
- **MUL:** shift-add, one multiplier bit per cycle, LSB first.
  - Add the multiplicand to the accumulator when the bit is 1.
  - The multiplicand shifts left, the multiplier shifts right.
  - Only the low `WIDTH` bits are kept; overflow is discarded.
- **DIV:** restoring division, one quotient bit per cycle, MSB first.
  - Shift {remainder, dividend} left.
  - Trial-subtract the divisor. If the result is non-negative, commit it and set the quotient bit to 1; otherwise the quotient bit is 0.
  - Operands are unsigned.
- **Iteration end:** the counter increments each active cycle. When the counter reaches `ITER`-1, the next edge goes to DONE.
- **DONE:** lasts one cycle.
  - `done_o`=1; `result_o`, `rem_o` and `rdaddr_o` are valid.
  - The next unfrozen edge returns to IDLE.
- **Requests while not in IDLE:** `start_i` is ignored in MUL, DIV and DONE. There is no back-to-back accept from DONE.
- **Flags:**
  - `busy_o` = state is MUL or DIV.
  - `done_o` = state is DONE.
  - Both are combinational from state.
- **Stall:** `memstall_i`=1 freezes state, counter, operands and outputs; nothing advances. `done_o` stays high for as long as DONE is frozen.
- **Reset:** all outputs and internal registers go to 0 and state goes to IDLE. This holds mid-operation too; an aborted operation produces no `done_o`.
- **Outputs outside DONE:** `result_o`, `rem_o` and `rdaddr_o` hold their last DONE values.

## Timing

- Acceptance edge E.
- `busy_o` is high in the cycles after E, through E+`ITER`.
- `done_o` is high in the single cycle after edge E+`ITER`, i.e. 33 cycles of latency at default `WIDTH`.
- Divide by zero: `done_o` is high in the cycle right after E, and `busy_o` never asserts.
- Each stalled cycle adds exactly one cycle to the latency.
- The cycle in which `start_i` is sampled has `busy_o`=0. The hazard logic must hold the dependent instruction from the following cycle.

## Configuration

- **`EX_MULDIV_DIV_EN` defined:** the DIV state, the restoring-divide datapath and `rem_o` logic are built.
- **`EX_MULDIV_DIV_EN` undefined:**
  - `DIVU` is accepted but goes directly to DONE with `result_o` = `{WIDTH{1'b1}}` and `rem_o` = 0. `busy_o` stays low.
  - MUL behaviour is unchanged.

## Structure

- Shared package `muldiv_pkg` holds:
  - the funct constants `FUNCT_MULU` and `FUNCT_DIVU`;
  - the state encoding IDLE, MUL, DIV, DONE;
  - the default `WIDTH`.
- One sub-module, `div_step`: the combinational shift, trial-subtract and select for one restoring iteration. It is instantiated only under `EX_MULDIV_DIV_EN`.
- The control FSM, counter and shift-add multiply stay in `ex_muldiv`.

## Test plan

- **Multiply:** `MULU` 7 × 6, rd=5 → `busy_o` for 32 cycles, then `done_o` for 1 cycle with `result_o`=42, `rem_o`=0, `rdaddr_o`=5.
- **Multiply overflow:** `MULU` 32'hFFFF_FFFF × 2 → `result_o`=32'hFFFF_FFFE after 33 cycles.
- **Divide:** `DIVU` 100 / 7 → `result_o`=14, `rem_o`=2.
  - Then `DIVU` 5 / 0 → `done_o` in the next cycle with `result_o`=32'hFFFF_FFFF, `rem_o`=5, and `busy_o` never high.
- **Stall in DIV:** `DIVU` 32'h8000_0000 / 3 with `memstall_i` high for 4 cycles at iteration 10 → `done_o` at cycle 37, `result_o`=32'h2AAA_AAAA, `rem_o`=2.
- **Ignored start:** `start_i` pulsed with `MULU` during MUL → no effect, and the first result is unchanged.
- **Reset mid-operation:** `rst_i` at iteration 20 → next cycle all outputs are 0 and state is IDLE, with no `done_o`. A fresh `MULU` 3 × 3 then returns 9.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: funct codes,
// control state encoding and the default datapath width.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [5:0] FUNCT_MULU = 6'b011001;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the ID/EX-EX/MEM pipeline and ex_muldiv.
// The pipeline side uses the master modport, the unit uses slave.
interface ex_muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             memstall_i;
    logic             start_i;
    logic [5:0]       funct_i;
    logic [WIDTH-1:0] rsdata_i;
    logic [WIDTH-1:0] rtdata_i;
    logic [4:0]       rdaddr_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic [WIDTH-1:0] rem_o;
    logic [4:0]       rdaddr_o;

    modport master (
        output memstall_i, start_i, funct_i, rsdata_i, rtdata_i, rdaddr_i,
        input  busy_o, done_o, result_o, rem_o, rdaddr_o
    );

    modport slave (
        input  memstall_i, start_i, funct_i, rsdata_i, rtdata_i, rdaddr_i,
        output busy_o, done_o, result_o, rem_o, rdaddr_o
    );
endinterface

// File: rtl/ex_muldiv_div_step.sv
// One restoring-division iteration: shift {remainder, dividend} left by one,
// trial-subtract the divisor and keep the difference only if it did not go
// negative. The freed dividend LSB receives the new quotient bit.
module div_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dq_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dq_o
);
    logic [WIDTH:0] shifted;
    logic           fits;

    // Shifted remainder can need WIDTH+1 bits; the difference always fits in
    // WIDTH bits once it is known to be non-negative.
    always_comb begin
        shifted = {rem_i, dq_i[WIDTH-1]};
        fits    = (shifted >= {1'b0, divisor_i});
        if (fits) begin
            rem_o = shifted[WIDTH-1:0] - divisor_i;
            dq_o  = {dq_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            dq_o  = {dq_i[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle unsigned multiply/divide unit for the EX stage.
// Shift-add multiply (LSB first) and, when EX_MULDIV_DIV_EN is defined,
// restoring division (MSB first). Without EX_MULDIV_DIV_EN a DIVU completes
// immediately with an all-ones quotient and zero remainder.
// memstall freezes every register; rst_i clears everything and aborts.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic       clk_i,
    input  logic       rst_i,
    ex_muldiv_if.slave bus
);
    localparam int               CNT_W    = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc: product accumulator (MUL) or partial remainder (DIV)
    logic [WIDTH-1:0] acc_q, acc_d;
    // opa: multiplicand (MUL) or dividend shifting into quotient (DIV)
    logic [WIDTH-1:0] opa_q, opa_d;
    // opb: multiplier (MUL) or divisor (DIV)
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [4:0]       rd_cap_q, rd_cap_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [4:0]       rdaddr_q, rdaddr_d;

    logic             req_valid;
    logic             req_mul;
    logic [WIDTH-1:0] mul_acc;

    assign req_mul   = (bus.funct_i == FUNCT_MULU);
    assign req_valid = bus.start_i && (req_mul || (bus.funct_i == FUNCT_DIVU));
    assign mul_acc   = acc_q + (opb_q[0] ? opa_q : '0);

`ifdef EX_MULDIV_DIV_EN
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_dq;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i     (acc_q),
        .dq_i      (opa_q),
        .divisor_i (opb_q),
        .rem_o     (div_rem),
        .dq_o      (div_dq)
    );
`endif

    // Next-state, datapath update and output capture for the control FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rd_cap_d = rd_cap_q;
        result_d = result_q;
        rem_d    = rem_q;
        rdaddr_d = rdaddr_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    opa_d    = bus.rsdata_i;
                    opb_d    = bus.rtdata_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    rd_cap_d = bus.rdaddr_i;
                    if (req_mul) begin
                        state_d = ST_MUL;
                    end else begin
`ifdef EX_MULDIV_DIV_EN
                        if (bus.rtdata_i != '0) begin
                            state_d = ST_DIV;
                        end else begin
                            // Divide by zero: finish at once, remainder is the dividend
                            state_d  = ST_DONE;
                            result_d = '1;
                            rem_d    = bus.rsdata_i;
                            rdaddr_d = bus.rdaddr_i;
                        end
`else
                        // No divider built: DIVU completes with a fixed answer
                        state_d  = ST_DONE;
                        result_d = '1;
                        rem_d    = '0;
                        rdaddr_d = bus.rdaddr_i;
`endif
                    end
                end
            end

            ST_MUL: begin
                acc_d = mul_acc;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    result_d = mul_acc;
                    rem_d    = '0;
                    rdaddr_d = rd_cap_q;
                end
            end

`ifdef EX_MULDIV_DIV_EN
            ST_DIV: begin
                acc_d = div_rem;
                opa_d = div_dq;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    result_d = div_dq;
                    rem_d    = div_rem;
                    rdaddr_d = rd_cap_q;
                end
            end
`endif

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over the memory stall freeze
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            rd_cap_q <= '0;
            result_q <= '0;
            rem_q    <= '0;
            rdaddr_q <= '0;
        end else if (!bus.memstall_i) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            rd_cap_q <= rd_cap_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            rdaddr_q <= rdaddr_d;
        end
    end

    assign bus.busy_o   = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign bus.done_o   = (state_q == ST_DONE);
    assign bus.result_o = result_q;
    assign bus.rem_o    = rem_q;
    assign bus.rdaddr_o = rdaddr_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv. Expected values are hand-computed;
// divide results depend on whether EX_MULDIV_DIV_EN is defined.
module tb_ex_muldiv;
    import muldiv_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    ex_muldiv_if #(.WIDTH(32)) bus ();

    ex_muldiv #(
        .WIDTH (32),
        .ITER  (32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request, then watches up to 80 cycles. Cycle k is the k-th
    // cycle after the acceptance edge; stall covers cycles stall_at..stall_at+3,
    // pulse_at drives a stray MULU request in that cycle.
    task automatic run_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [4:0] rd, input int stall_at, input int pulse_at,
                          output int busy_n, output int done_k, output int done_n,
                          output logic [31:0] res, output logic [31:0] remv, output logic [4:0] rdo);
        busy_n = 0; done_k = 0; done_n = 0; res = '0; remv = '0; rdo = '0;
        @(negedge clk);
        chk("busy_in_sample_cycle", {31'd0, bus.busy_o}, 32'd0);
        bus.start_i = 1'b1; bus.funct_i = f; bus.rsdata_i = rs; bus.rtdata_i = rt; bus.rdaddr_i = rd;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0; bus.funct_i = 6'd0; bus.rsdata_i = '0; bus.rtdata_i = '0; bus.rdaddr_i = '0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (bus.busy_o) busy_n++;
            if (bus.done_o) begin
                done_n++;
                if (done_k == 0) begin
                    done_k = k;
                    res    = bus.result_o;
                    remv   = bus.rem_o;
                    rdo    = bus.rdaddr_o;
                end
            end
            bus.memstall_i = (stall_at > 0) && (k >= stall_at) && (k < stall_at + 4);
            if (k == pulse_at) begin
                bus.start_i = 1'b1; bus.funct_i = FUNCT_MULU;
                bus.rsdata_i = 32'd9; bus.rtdata_i = 32'd9; bus.rdaddr_i = 5'd1;
            end else begin
                bus.start_i = 1'b0; bus.funct_i = 6'd0;
                bus.rsdata_i = '0; bus.rtdata_i = '0; bus.rdaddr_i = '0;
            end
        end
        bus.memstall_i = 1'b0;
    endtask

    task automatic op_check(input string name, input logic [5:0] f, input logic [31:0] rs,
                            input logic [31:0] rt, input logic [4:0] rd, input int stall_at,
                            input int pulse_at, input logic [31:0] exp_res, input logic [31:0] exp_rem,
                            input int exp_done_k, input int exp_busy);
        int busy_n, done_k, done_n;
        logic [31:0] res, remv;
        logic [4:0]  rdo;
        run_op(f, rs, rt, rd, stall_at, pulse_at, busy_n, done_k, done_n, res, remv, rdo);
        $display("op %s: rs=%h rt=%h -> result=%h rem=%h rd=%0d done_cycle=%0d busy_cycles=%0d",
                 name, rs, rt, res, remv, rdo, done_k, busy_n);
        chk({name, "_result"}, res, exp_res);
        chk({name, "_rem"}, remv, exp_rem);
        chk({name, "_rdaddr"}, {27'd0, rdo}, {27'd0, rd});
        chk({name, "_done_cycle"}, done_k, exp_done_k);
        chk({name, "_done_count"}, done_n, 1);
        chk({name, "_busy_cycles"}, busy_n, exp_busy);
    endtask

    initial begin
        int saw_done;
        n_cmp = 0; n_err = 0;
        rst = 1'b1;
        bus.memstall_i = 1'b0; bus.start_i = 1'b0; bus.funct_i = 6'd0;
        bus.rsdata_i = '0; bus.rtdata_i = '0; bus.rdaddr_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("reset_done", {31'd0, bus.done_o}, 32'd0);
        chk("reset_result", bus.result_o, 32'd0);
        chk("reset_rem", bus.rem_o, 32'd0);
        chk("reset_rdaddr", {27'd0, bus.rdaddr_o}, 32'd0);

        op_check("mul_7x6", FUNCT_MULU, 32'd7, 32'd6, 5'd5, 0, 0, 32'd42, 32'd0, 33, 32);
        op_check("mul_ovf", FUNCT_MULU, 32'hFFFF_FFFF, 32'd2, 5'd9, 0, 0, 32'hFFFF_FFFE, 32'd0, 33, 32);
`ifdef EX_MULDIV_DIV_EN
        op_check("div_100_7", FUNCT_DIVU, 32'd100, 32'd7, 5'd3, 0, 0, 32'd14, 32'd2, 33, 32);
        op_check("div_5_0", FUNCT_DIVU, 32'd5, 32'd0, 5'd4, 0, 0, 32'hFFFF_FFFF, 32'd5, 1, 0);
        op_check("div_stall", FUNCT_DIVU, 32'h8000_0000, 32'd3, 5'd6, 10, 0, 32'h2AAA_AAAA, 32'd2, 37, 36);
`else
        op_check("div_100_7", FUNCT_DIVU, 32'd100, 32'd7, 5'd3, 0, 0, 32'hFFFF_FFFF, 32'd0, 1, 0);
        op_check("div_5_0", FUNCT_DIVU, 32'd5, 32'd0, 5'd4, 0, 0, 32'hFFFF_FFFF, 32'd0, 1, 0);
        op_check("div_stall", FUNCT_DIVU, 32'h8000_0000, 32'd3, 5'd6, 10, 0, 32'hFFFF_FFFF, 32'd0, 1, 0);
`endif
        op_check("mul_stall", FUNCT_MULU, 32'd1000, 32'd1000, 5'd7, 5, 0, 32'd1000000, 32'd0, 37, 36);
        op_check("mul_ignored_start", FUNCT_MULU, 32'd7, 32'd6, 5'd5, 0, 5, 32'd42, 32'd0, 33, 32);

        // Reset in the middle of a multiply aborts it with no done pulse
        @(negedge clk);
        bus.start_i = 1'b1; bus.funct_i = FUNCT_MULU;
        bus.rsdata_i = 32'd11; bus.rtdata_i = 32'd13; bus.rdaddr_i = 5'd12;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0; bus.funct_i = 6'd0;
        bus.rsdata_i = '0; bus.rtdata_i = '0; bus.rdaddr_i = '0;
        repeat (20) @(negedge clk);
        chk("pre_reset_busy", {31'd0, bus.busy_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("midreset_done", {31'd0, bus.done_o}, 32'd0);
        chk("midreset_result", bus.result_o, 32'd0);
        chk("midreset_rem", bus.rem_o, 32'd0);
        chk("midreset_rdaddr", {27'd0, bus.rdaddr_o}, 32'd0);
        saw_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done_o || bus.busy_o) saw_done++;
        end
        chk("midreset_quiet", saw_done, 0);
        $display("op reset_mid_mul: aborted, outputs result=%h rem=%h rd=%0d",
                 bus.result_o, bus.rem_o, bus.rdaddr_o);

        op_check("mul_3x3", FUNCT_MULU, 32'd3, 32'd3, 5'd8, 0, 0, 32'd9, 32'd0, 33, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
